// File: rtl/hdmi_ts_pkg.sv
// Shared constants and state encoding for the HDMI receive-side timing blocks.
package hdmi_ts_pkg;

  localparam int unsigned ADE_LEN = 32;
  localparam int unsigned H_TOTAL = 1650;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StArmed,
    StActive
  } ade_state_e;

endpackage

// File: rtl/ade_line_counter.sv
// Counts completed ade windows per line; the count is latched into ade_num on each vde rise.
module ade_line_counter #(
  parameter int unsigned NUM_W = 4
) (
  input  logic             fifo_clk,
  input  logic             sys_rst,
  input  logic             vde,
  input  logic             win_done,
  output logic             vde_rise,
  output logic [NUM_W-1:0] ade_num
);

  localparam logic [NUM_W-1:0] CntMax = '1;
  localparam logic [NUM_W-1:0] CntOne = NUM_W'(1);

  logic             vde_q;
  logic [NUM_W-1:0] cnt_q;

  assign vde_rise = vde & ~vde_q;

  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      vde_q   <= 1'b0;
      cnt_q   <= '0;
      ade_num <= '0;
    end else begin
      vde_q <= vde;
      if (vde_rise) begin
        ade_num <= cnt_q;
        // A window finishing on the rising edge belongs to the new line.
        cnt_q   <= win_done ? CntOne : '0;
      end else if (win_done && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

endmodule

// File: rtl/ade_scheduler.sv
// Pops aux slot positions and opens a fixed-length ade window when the raster reaches each
// slot outside active video.
module ade_scheduler
  import hdmi_ts_pkg::*;
#(
  parameter int unsigned HCNT_W  = 11,
  parameter int unsigned SLOT_W  = 12,
  parameter int unsigned H_TOTAL = hdmi_ts_pkg::H_TOTAL,
  parameter int unsigned ADE_LEN = hdmi_ts_pkg::ADE_LEN,
  parameter int unsigned NUM_W   = 4
) (
  input  logic              fifo_clk,
  input  logic              sys_rst,
  input  logic [HCNT_W-1:0] hcnt,
  input  logic              vde,
  input  logic              ax_empty,
  input  logic [SLOT_W-1:0] ax_dout,
  output logic              ax_rd_en,
  output logic              ade,
  output logic [4:0]        ade_idx,
  output logic [NUM_W-1:0]  ade_num,
  output logic              slot_err,
  output logic              ovl_err
);

  localparam logic [SLOT_W-1:0] SlotLimit = SLOT_W'(H_TOTAL);
  localparam logic [4:0]        LastIdx   = 5'(ADE_LEN - 1);

  ade_state_e        state_q;
  logic [HCNT_W-1:0] slot_q;
  logic              vde_rise;
  logic              win_done;

  // Read strobe is decoded from state so data lands exactly in the LOAD cycle.
  assign ax_rd_en = (state_q == StFetch) && !ax_empty;
  assign win_done = (state_q == StActive) && (ade_idx == LastIdx);

  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      ade      <= 1'b0;
      ade_idx  <= '0;
      slot_err <= 1'b0;
      ovl_err  <= 1'b0;
    end else begin
      slot_err <= 1'b0;
      ovl_err  <= vde_rise & ade;
      unique case (state_q)
        StIdle: begin
          if (vde) state_q <= StFetch;
        end
        StFetch: begin
          if (!ax_empty) state_q <= StLoad;
        end
        StLoad: begin
          slot_q <= ax_dout[HCNT_W-1:0];
          if (ax_dout >= SlotLimit) begin
            slot_err <= 1'b1;
            state_q  <= StFetch;
          end else begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          // A match inside active video is skipped; the slot retries on a later line.
          if ((hcnt == slot_q) && !vde) begin
            state_q <= StActive;
            ade     <= 1'b1;
            ade_idx <= '0;
          end
        end
        StActive: begin
          if (ade_idx == LastIdx) begin
            ade     <= 1'b0;
            ade_idx <= '0;
            state_q <= StFetch;
          end else begin
            ade_idx <= ade_idx + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ade_line_counter #(
    .NUM_W(NUM_W)
  ) u_line_counter (
    .fifo_clk(fifo_clk),
    .sys_rst (sys_rst),
    .vde     (vde),
    .win_done(win_done),
    .vde_rise(vde_rise),
    .ade_num (ade_num)
  );

endmodule

// File: tb/tb_ade_scheduler.sv
// Scoreboard bench: a raster-level model predicts read, window, error and line-count events.
module tb_ade_scheduler;

  localparam int HT = 1650;
  localparam int HA = 1280;
  localparam int VT = 5;
  localparam int VA = 3;
  localparam int AL = 32;

  logic        fifo_clk = 1'b0;
  logic        sys_rst  = 1'b1;
  logic [10:0] hcnt     = '0;
  logic        vde      = 1'b0;
  logic        ax_empty = 1'b1;
  logic [11:0] ax_dout  = '0;
  logic        ax_rd_en, ade, slot_err, ovl_err;
  logic [4:0]  ade_idx;
  logic [3:0]  ade_num;

  ade_scheduler dut (
    .fifo_clk(fifo_clk),
    .sys_rst (sys_rst),
    .hcnt    (hcnt),
    .vde     (vde),
    .ax_empty(ax_empty),
    .ax_dout (ax_dout),
    .ax_rd_en(ax_rd_en),
    .ade     (ade),
    .ade_idx (ade_idx),
    .ade_num (ade_num),
    .slot_err(slot_err),
    .ovl_err (ovl_err)
  );

  always #5 fifo_clk = ~fifo_clk;

  typedef struct packed {
    int cyc;
    int val;
  } ev_t;

  ev_t         rdq[$], winq[$], errq[$], ovlq[$], numq[$];
  logic [11:0] fifo[$];
  int          slots[$];
  int unsigned checks = 0, errors = 0;
  int          cyc = 0, c0 = 0, mon_lo = 0, mon_hi = 0, q_lo = 0, q_hi = 0, mode = 0;
  int          flush_cnt = 0, flush_seen = 0;
  bit          running = 0;

  function automatic ev_t mk(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // Raster: VT lines per frame, first VA lines carry HA active pixels; mode 1 adds a stray
  // vde pulse late on line 0.
  function automatic bit vde_of(input int rel, input int m);
    int line, h;
    if (rel < 0) return 1'b0;
    line = rel / HT;
    h    = rel % HT;
    if (m == 1 && line == 0 && h >= 1550 && h < 1600) return 1'b1;
    return ((line % VT) < VA) && (h < HA);
  endfunction

  task automatic tick();
    logic rd;
    @(negedge fifo_clk);
    rd = ax_rd_en;
    @(posedge fifo_clk);
    #1;
    cyc++;
    if (rd && fifo.size() > 0) ax_dout = fifo.pop_front();
    if (running && cyc >= c0) begin
      hcnt = 11'((cyc - c0) % HT);
      vde  = vde_of(cyc - c0, mode);
    end else begin
      hcnt = '0;
      vde  = 1'b0;
    end
    ax_empty = (fifo.size() == 0);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: compares DUT activity against the predicted event queues.
  bit  ade_prev = 0, idx_ok = 0;
  int  win_len = 0;
  ev_t e;
  always @(negedge fifo_clk) begin
    if (flush_cnt != flush_seen) begin
      flush_seen = flush_cnt;
      chk("pending events", rdq.size() + winq.size() + errq.size() + ovlq.size() + numq.size(),
          0);
      rdq.delete(); winq.delete(); errq.delete(); ovlq.delete(); numq.delete();
    end
    if (cyc >= q_lo && cyc < q_hi) begin
      chk("quiet outputs", int'({ax_rd_en, ade, slot_err, ovl_err, ade_idx, ade_num}), 0);
    end
    if (cyc >= mon_lo && cyc < mon_hi) begin
      if (ax_rd_en) begin
        if (rdq.size() > 0) begin e = rdq.pop_front(); chk("rd_en cycle", cyc, e.cyc); end
        else chk("rd_en unexpected", cyc, -1);
      end
      if (slot_err) begin
        if (errq.size() > 0) begin e = errq.pop_front(); chk("slot_err cycle", cyc, e.cyc); end
        else chk("slot_err unexpected", cyc, -1);
      end
      if (ovl_err) begin
        if (ovlq.size() > 0) begin e = ovlq.pop_front(); chk("ovl_err cycle", cyc, e.cyc); end
        else chk("ovl_err unexpected", cyc, -1);
      end
      if (numq.size() > 0 && numq[0].cyc == cyc) begin
        e = numq.pop_front();
        chk("ade_num", int'(ade_num), e.val);
      end
      if (ade && !ade_prev) begin
        if (winq.size() > 0) begin e = winq.pop_front(); chk("ade start cycle", cyc, e.cyc); end
        else chk("ade unexpected", cyc, -1);
        win_len = 1;
        idx_ok  = (ade_idx == 5'd0);
      end else if (ade && ade_prev) begin
        win_len++;
        if (ade_idx != 5'(win_len - 1)) idx_ok = 1'b0;
      end else if (!ade && ade_prev) begin
        chk("ade window length", win_len, AL);
        chk("ade_idx sequence", int'(idx_ok), 1);
      end
      ade_prev = ade;
    end else begin
      ade_prev = 1'b0;
    end
  end

  task automatic scenario(input int m, input int pre, input int horizon, input int cut,
                          input bit quiet_after);
    int end_rel, f, t, s, prev, cnt;
    int comps[$], wins[$];
    sys_rst = 1'b1;
    running = 1'b0;
    tick();
    tick();
    mode = m;
    fifo.delete();
    foreach (slots[i]) fifo.push_back(12'(slots[i]));
    ax_empty = (fifo.size() == 0);
    sys_rst  = 1'b0;
    c0       = cyc + pre + 1;
    if (pre > 0) begin q_lo = cyc; q_hi = c0; end
    end_rel = (cut > 0) ? cut : horizon;
    // One fetch per slot; a valid slot waits for the first blank cycle at its position.
    f = 1;
    for (int i = 0; i < slots.size(); i++) begin
      if (f >= end_rel) break;
      rdq.push_back(mk(c0 + f, 0));
      s = slots[i];
      if (s >= HT) begin
        if (f + 2 < end_rel) errq.push_back(mk(c0 + f + 2, 0));
        f += 2;
        continue;
      end
      t = f + 2;
      while (t < end_rel && !((t % HT) == s && !vde_of(t, m))) t++;
      if (t >= end_rel) break;
      wins.push_back(t + 1);
      comps.push_back(t + AL);
      if (cut == 0 && t + AL + 2 > end_rel) end_rel = t + AL + 2;
      f = t + AL + 1;
    end
    foreach (wins[k]) if (wins[k] < end_rel) winq.push_back(mk(c0 + wins[k], 0));
    prev = -1000000;
    for (int r = 0; r + 1 < end_rel; r++) begin
      if (vde_of(r, m) && !vde_of(r - 1, m)) begin
        cnt = 0;
        foreach (comps[k]) if (comps[k] >= prev && comps[k] <= r - 1) cnt++;
        numq.push_back(mk(c0 + r + 1, (cnt > 15) ? 15 : cnt));
        foreach (wins[k]) if (wins[k] <= r && r <= wins[k] + AL - 1) ovlq.push_back(mk(c0 + r + 1, 0));
        prev = r;
      end
    end
    mon_lo  = cyc;
    mon_hi  = c0 + end_rel;
    running = 1'b1;
    while (cyc < c0 + end_rel - 1) tick();
    sys_rst = 1'b1;
    running = 1'b0;
    if (quiet_after) begin q_lo = c0 + end_rel; q_hi = q_lo + 40; end
    tick();
    flush_cnt++;
    if (quiet_after) begin
      fifo.push_back(12'h100);
      ax_empty = 1'b0;
      sys_rst  = 1'b0;
      repeat (41) tick();
    end
  endtask

  initial begin
    // Idle: vde low for 2000 cycles with a queued slot.
    slots = {12'h100};
    scenario(0, 2000, 200, 0, 1'b0);
    // Basic slot, then a second slot fetched right after the window.
    slots = {12'h5DD, 12'h600};
    scenario(0, 0, 3300, 0, 1'b0);
    // Slot inside active video fires on the first blanking line.
    slots = {12'h0FA};
    scenario(0, 0, 5300, 0, 1'b0);
    // Invalid slot followed by a slot blocked until vblank.
    slots = {12'h700, 12'h010};
    scenario(0, 0, 5000, 0, 1'b0);
    // Three windows in one hblank.
    slots = {1300, 1400, 1500};
    scenario(0, 0, 1700, 0, 1'b0);
    // Twenty minimum-gap windows on a vblank line saturate the count.
    slots.delete();
    for (int i = 0; i < 20; i++) slots.push_back(10 + 35 * i);
    scenario(0, 0, 8300, 0, 1'b0);
    // vde pulse rising mid-window.
    slots = {12'h5FF};
    scenario(1, 0, 1700, 0, 1'b0);
    // Reset at ade_idx 10, then the block must sit idle.
    slots = {12'h5DD};
    scenario(0, 0, 0, 1513, 1'b1);
    // Randomized slot lists, including out-of-range entries.
    repeat (2) begin
      slots.delete();
      repeat ($urandom_range(3, 7)) begin
        if ($urandom_range(0, 4) == 0) slots.push_back($urandom_range(HT, 4095));
        else slots.push_back($urandom_range(0, HT - 1));
      end
      scenario(0, 0, 8300, 0, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
